oflow_core_set_dispatch: RTL



---
 rtl/oflow_core_set_dispatch.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/oflow_core_set_dispatch.sv
// Per-set sequencer below the core top FSM: walks one frame's sets through the PE array,
// launching enabled PEs per DMA set and reporting completed sets / frame completion upstream.
module oflow_core_set_dispatch #(
    parameter int PE_NUM          = 24,
    parameter int SET_LEN         = 4,
    parameter int REMAIN_BBOX_LEN = 8
) (
    input  logic                       clk,
    input  logic                       reset_N,
    input  logic                       start_pe,
    input  logic [SET_LEN-1:0]         num_of_sets,
    input  logic                       new_set,
    input  logic [REMAIN_BBOX_LEN-1:0] counter_of_remain_bboxes,
    input  logic [PE_NUM-1:0]          pe_done,
    output logic                       pe_start,
    output logic [PE_NUM-1:0]          pe_en,
    output logic                       set_ack,
    output logic [SET_LEN-1:0]         counter_set_fe,
    output logic                       done_pe,
    output logic                       busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SET = 3'd1,
        LOAD     = 3'd2,
        CALC     = 3'd3,
        SET_DONE = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [SET_LEN-1:0]    num_sets_r;
    logic [SET_LEN-1:0]    cnt_r;
    logic [SET_LEN-1:0]    cnt_inc_s;
    logic                  pending_r;
    logic [PE_NUM-1:0]     en_r;
    logic [PE_NUM-1:0]     done_acc_r;
    logic                  pe_start_r;
    logic                  set_ack_r;
    logic                  done_pe_r;
    logic                  busy_r;
    logic                  calc_done_s;
    logic                  last_set_s;
    logic                  start_acc_s;
    logic                  zero_sets_s;

    // One enable bit per remaining bbox, saturating at the full array.
    function automatic logic [PE_NUM-1:0] make_mask(input logic [REMAIN_BBOX_LEN-1:0] remain);
        logic [PE_NUM-1:0] m;
        m = {PE_NUM{1'b0}};
        for (int i = 0; i < PE_NUM; i++) begin
            m[i] = (32'(remain) > 32'(i));
        end
        return m;
    endfunction

    // Next-state decode and frame-level qualifiers.
    always_comb begin
        state_s     = state_r;
        cnt_inc_s   = cnt_r + SET_LEN'(1'b1);
        calc_done_s = (((done_acc_r | pe_done) & en_r) == en_r);
        last_set_s  = (cnt_inc_s == num_sets_r);
        start_acc_s = (state_r == IDLE) && start_pe;
        zero_sets_s = (num_of_sets == {SET_LEN{1'b0}});
        case (state_r)
            IDLE: begin
                if (start_pe && !zero_sets_s) begin
                    state_s = WAIT_SET;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_SET: begin
                if (new_set || pending_r) begin
                    state_s = LOAD;
                end else begin
                    state_s = WAIT_SET;
                end
            end
            LOAD: begin
                state_s = CALC;
            end
            CALC: begin
                if (calc_done_s) begin
                    state_s = SET_DONE;
                end else begin
                    state_s = CALC;
                end
            end
            SET_DONE: begin
                if (last_set_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_SET;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, frame bookkeeping and registered strobes.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_r    <= IDLE;
            num_sets_r <= {SET_LEN{1'b0}};
            cnt_r      <= {SET_LEN{1'b0}};
            pe_start_r <= 1'b0;
            set_ack_r  <= 1'b0;
            done_pe_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            pe_start_r <= (state_s == LOAD);
            set_ack_r  <= (state_s == LOAD);
            busy_r     <= (state_s != IDLE);
            done_pe_r  <= (start_acc_s && zero_sets_s) || ((state_r == SET_DONE) && last_set_s);
            if (start_acc_s) begin
                num_sets_r <= num_of_sets;
                cnt_r      <= {SET_LEN{1'b0}};
            end else if (state_r == SET_DONE) begin
                cnt_r      <= cnt_inc_s;
            end
        end
    end

    // A DMA set announced while we are busy elsewhere is remembered once.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            pending_r <= 1'b0;
        end else if (start_acc_s) begin
            pending_r <= 1'b0;
        end else if ((state_r == WAIT_SET) && (state_s == LOAD)) begin
            pending_r <= 1'b0;
        end else if (new_set && (state_r != IDLE) && (state_r != WAIT_SET)) begin
            pending_r <= 1'b1;
        end
    end

    // Enable mask and sticky completion accumulator for the set in flight.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            en_r       <= {PE_NUM{1'b0}};
            done_acc_r <= {PE_NUM{1'b0}};
        end else begin
            if (state_r == LOAD) begin
                en_r <= make_mask(counter_of_remain_bboxes);
            end else if ((state_s == IDLE) || (state_s == WAIT_SET)) begin
                en_r <= {PE_NUM{1'b0}};
            end
            if (state_r == LOAD) begin
                done_acc_r <= {PE_NUM{1'b0}};
            end else if (state_r == CALC) begin
                done_acc_r <= done_acc_r | (pe_done & en_r);
            end
        end
    end

    assign pe_start       = pe_start_r;
    assign set_ack        = set_ack_r;
    assign pe_en          = en_r;
    assign counter_set_fe = cnt_r;
    assign done_pe        = done_pe_r;
    assign busy           = busy_r;

endmodule
